ecc_host_port: RTL and testbench
================================

Name: ecc_host_port

Overview:
- Byte-serial host-side initiator for the ecc arithmetic core.
- Accepts a command frame over a valid/ready byte stream.
- Drives the core's inst, a0..a4 and b0..b4 inputs, waits a fixed compute latency, then captures c0..c4.
- Returns the 5 result bytes over a second valid/ready byte stream; sits between the system bus/UART bridge and the ecc core.

Parameters:
- LATENCY, 16, cycles from the operand-stable point to the result-capture point; valid range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  host command/operand byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  8  result byte.
- out_valid  output  1  out_data valid.
- out_ready  input  1  host accepts out_data.
- busy  output  1  high from command-byte accept until the last result byte is accepted.
- done  output  1  one-cycle pulse when the last result byte is accepted.
- inst  output  3  operation code to the core (cmd byte bits [2:0]).
- a0..a4  output  8 each  operand A bytes to the core, a0 least significant.
- b0..b4  output  8 each  operand B bytes to the core, b0 least significant.
- c0..c4  input  8 each  result bytes from the core, c0 least significant.

Behaviour:
- Reset (async, active-high) forces:
  - all outputs to 0 (in_ready 0 during reset);
  - state IDLE and counters 0.
  - On the first clk edge after reset deassertion, in_ready becomes 1.
- Transfer rule: a byte moves when valid && ready on a rising edge. out_data/out_valid hold stable until accepted.
- Frame: 11 bytes, always in this order: cmd, A0..A4, B0..B4. All 11 bytes are sent even for single-operand ops; B is still loaded. Cmd bits [7:3] are ignored.
- FSM states:
  - IDLE: in_ready=1, busy=0. Cmd accepted -> inst<=cmd[2:0], idx<=0, busy<=1, go LOAD_A.
  - LOAD_A: in_ready=1. Each accepted byte writes a[idx], idx++. After A4 -> idx<=0, go LOAD_B.
  - LOAD_B: as LOAD_A, writing b[idx]. After B4 -> wcnt<=0, go WAIT.
  - WAIT: in_ready=0. wcnt increments each cycle; when wcnt==LATENCY-1, latch c0..c4 into a result buffer, idx<=0, go UNLOAD.
  - UNLOAD: out_valid=1, out_data=res[idx]. Each accept idx++. After res4 accepted -> done pulse, busy<=0, out_valid<=0, go IDLE.
- Register stability:
  - inst, a*, b* are registered and change only on accepted bytes. They hold their values through WAIT, UNLOAD and IDLE until overwritten by the next frame.
  - The result buffer decouples out_data from later changes on c*.
- Latency: with no back-pressure, result byte 0 is valid exactly LATENCY+1 cycles after the B4 accept edge.
- Boundary cases:
  - in_valid gaps are legal anywhere within a frame; the FSM waits indefinitely with no timeout.
  - in_ready is 0 in WAIT/UNLOAD, so a next cmd byte offered during the last result accept is taken the following cycle (IDLE).
  - out_ready held low stalls UNLOAD indefinitely with data stable.
  - Reset mid-frame or mid-unload aborts the operation: all registers clear and no done pulse is produced.
  - idx never exceeds 4; a 3-bit counter compared against 4.

Decomposition:
- Shared package ecc_pkg:
  - constants ECC_BYTES=5 and FRAME_LEN=11;
  - state enum {IDLE, LOAD_A, LOAD_B, WAIT, UNLOAD};
  - inst code constants shared with the core's output selector.
- One natural sub-module: ecc_latency_timer, a loadable wait counter with a terminal pulse, reused by other multicycle GF blocks.
- Operand and result registers stay in the top.

Test Plan:
- Reset 3 cycles, then release -> all outputs 0, busy 0; in_ready 1 on the next edge.
- Frame cmd=0x01, A=01 02 03 04 05, B=10 20 30 40 50, core model returns c=AA BB CC DD EE with out_ready=1:
  - a0..a4=01..05, b0..b4=10..50, inst=1 during WAIT;
  - out_data sequence AA,BB,CC,DD,EE starting LATENCY+1 cycles after B4;
  - done pulses once.
- Same frame with in_valid toggled 1/0 every cycle and out_ready low for 7 cycles on byte 2 -> identical operands and results; out_data stable =CC during the stall.
- Cmd byte 0xFA -> inst=3'b010 (upper bits ignored); the frame completes normally.
- Reset asserted in WAIT after 5 cycles -> outputs immediately 0, no out_valid and no done; a following full frame completes correctly.
- Back-to-back frames, second cmd offered in the same cycle as the last result accept -> cmd taken the next cycle; the second result is correct and the first frame's results are not corrupted.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared definitions for the ecc host port and its helpers: frame geometry,
// controller states and the operation codes understood by the ecc core.
package ecc_pkg;

    localparam int ECC_BYTES = 5;
    localparam int FRAME_LEN = 11;

    // Highest operand/result byte index; idx counters are 3 bits wide.
    localparam logic [2:0] IDX_LAST = 3'(ECC_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UNLOAD = 3'd4
    } ecc_state_e;

    // Operation codes shared with the core's output selector.
    localparam logic [2:0] INST_ADD = 3'd0;
    localparam logic [2:0] INST_MUL = 3'd1;
    localparam logic [2:0] INST_SQR = 3'd2;
    localparam logic [2:0] INST_INV = 3'd3;

endpackage

// File: rtl/ecc_latency_timer.sv
// Loadable wait counter for multicycle GF blocks. A load restarts the count at
// zero; when the count reaches limit-1 a one-cycle tick is registered and the
// timer goes idle until the next load.
module ecc_latency_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] limit,
    output logic         tick
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         active_q, active_d;
    logic         tick_q, tick_d;

    // Next-state for the counter, run flag and terminal pulse.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        tick_d   = 1'b0;
        if (load) begin
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q == limit - W'(1)) begin
                active_d = 1'b0;
                tick_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            tick_q   <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/ecc_host_port.sv
// Byte-serial host initiator for the ecc arithmetic core. Collects an 11-byte
// command frame (cmd, A0..A4, B0..B4), presents the operands to the core, waits
// the core latency, snapshots the result and streams the 5 result bytes back.
module ecc_host_port
    import ecc_pkg::*;
#(
    parameter int unsigned LATENCY = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic [2:0] inst,
    output logic [7:0] a0, a1, a2, a3, a4,
    output logic [7:0] b0, b1, b2, b3, b4,
    input  logic [7:0] c0, c1, c2, c3, c4
);

    ecc_state_e state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] inst_q, inst_d;
    logic [7:0] a_q [ECC_BYTES];
    logic [7:0] a_d [ECC_BYTES];
    logic [7:0] b_q [ECC_BYTES];
    logic [7:0] b_d [ECC_BYTES];
    logic [7:0] res_q [ECC_BYTES];
    logic [7:0] res_d [ECC_BYTES];
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic in_acc, out_acc, timer_load, timer_tick;

    assign in_acc  = in_valid && in_ready_q;
    assign out_acc = out_valid_q && out_ready;

    // The wait is measured from the B4 accept; the tick is registered, so the
    // capture lands one cycle after the count reaches LATENCY-1.
    ecc_latency_timer #(.W(8)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .limit (8'(LATENCY)),
        .tick  (timer_tick)
    );

    // Frame controller: next state, byte index and register updates.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        idx_d      = idx_q;
        inst_d     = inst_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        done_d     = 1'b0;
        timer_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_acc) begin
                    inst_d  = in_data[2:0];
                    idx_d   = '0;
                    state_d = ST_LOAD_A;
                end
            end
            ST_LOAD_A: begin
                if (in_acc) begin
                    a_d[idx_q] = in_data;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_LOAD_B;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_LOAD_B: begin
                if (in_acc) begin
                    b_d[idx_q] = in_data;
                    if (idx_q == IDX_LAST) begin
                        idx_d      = '0;
                        timer_load = 1'b1;
                        state_d    = ST_WAIT;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (timer_tick) begin
                    res_d   = '{c0, c1, c2, c3, c4};
                    idx_d   = '0;
                    state_d = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                if (out_acc) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Handshake flags are registered images of the next state, which keeps
        // in_ready low while reset is held and raises it on the first edge after.
        in_ready_d  = state_d inside {ST_IDLE, ST_LOAD_A, ST_LOAD_B};
        out_valid_d = (state_d == ST_UNLOAD);
        busy_d      = (state_d != ST_IDLE);
    end

    // Controller and data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            inst_q      <= '0;
            // NOTE: the operand and result arrays are reset as well, because an
            // aborted frame must leave nothing stale on the core-facing outputs.
            a_q         <= '{default: '0};
            b_q         <= '{default: '0};
            res_q       <= '{default: '0};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // values from before this edge, independent of statement order.
            state_q     <= state_d;
            idx_q       <= idx_d;
            inst_q      <= inst_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = res_q[idx_q];
    assign busy      = busy_q;
    assign done      = done_q;
    assign inst      = inst_q;
    assign a0 = a_q[0];
    assign a1 = a_q[1];
    assign a2 = a_q[2];
    assign a3 = a_q[3];
    assign a4 = a_q[4];
    assign b0 = b_q[0];
    assign b1 = b_q[1];
    assign b2 = b_q[2];
    assign b3 = b_q[3];
    assign b4 = b_q[4];

endmodule

// File: tb/tb_ecc_host_port.sv
// Directed bench for ecc_host_port: inputs are driven and outputs sampled on
// the falling clock edge; the core is modelled by constant result bytes.
module tb_ecc_host_port;

    localparam int unsigned LATENCY = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic [2:0] inst;
    logic [7:0] a0, a1, a2, a3, a4;
    logic [7:0] b0, b1, b2, b3, b4;
    logic [7:0] c_in [5];

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int cyc;
    bit ov_seen;

    ecc_host_port #(.LATENCY(LATENCY)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .inst      (inst),
        .a0 (a0), .a1 (a1), .a2 (a2), .a3 (a3), .a4 (a4),
        .b0 (b0), .b1 (b1), .b2 (b2), .b3 (b3), .b4 (b4),
        .c0 (c_in[0]), .c1 (c_in[1]), .c2 (c_in[2]), .c3 (c_in[3]), .c4 (c_in[4])
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_core(input logic [39:0] v);
        for (int i = 0; i < 5; i++) c_in[i] = v[8*i +: 8];
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        int tries;
        repeat (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        tries    = 0;
        while (in_ready !== 1'b1 && tries < 200) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 200) check("in_ready_timeout", 64'(tries), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_ops(input logic [39:0] a, input logic [39:0] b, input int gap);
        for (int i = 0; i < 5; i++) send_byte(a[8*i +: 8], gap);
        for (int i = 0; i < 5; i++) send_byte(b[8*i +: 8], gap);
    endtask

    task automatic check_ops(input logic [39:0] a, input logic [39:0] b, input logic [2:0] op);
        check("a_regs", {a4, a3, a2, a1, a0}, a);
        check("b_regs", {b4, b3, b2, b1, b0}, b);
        check("inst_wait", inst, op);
        check("in_ready_wait", in_ready, 1'b0);
        check("busy_wait", busy, 1'b1);
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 300) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 300) check("out_valid_timeout", 64'(cycles), 64'd0);
    endtask

    task automatic recv(input logic [39:0] exp, input int stall_idx, input int stall_n,
                        input bit overlap, input logic [7:0] nxt);
        int w;
        for (int i = 0; i < 5; i++) begin
            wait_valid(w);
            check($sformatf("out_data[%0d]", i), out_data, exp[8*i +: 8]);
            if (i == 0) for (int k = 0; k < 5; k++) c_in[k] = ~exp[8*k +: 8];
            if (i == stall_idx) begin
                out_ready = 1'b0;
                repeat (stall_n) begin
                    @(negedge clk);
                    check("stall_data", {out_valid, out_data}, {1'b1, exp[8*i +: 8]});
                end
                out_ready = 1'b1;
            end
            if (i == 4 && overlap) begin
                in_valid = 1'b1;
                in_data  = nxt;
            end
            @(negedge clk);
        end
        check("done_pulse", done, 1'b1);
        check("busy_end", busy, 1'b0);
        check("out_valid_end", out_valid, 1'b0);
        check("in_ready_end", in_ready, 1'b1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        set_core(40'h0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_flags", {out_valid, busy, done}, 3'b000);
        check("rst_out_data", out_data, 8'h00);
        check("rst_inst", inst, 3'd0);
        check("rst_ab", {a4, a3, a2, a1, a0, b4, b3, b2, b1, b0}, 80'h0);
        reset = 1'b0;
        #1 check("rel_in_ready_low", in_ready, 1'b0);
        @(negedge clk);
        check("rel_in_ready_high", in_ready, 1'b1);
        check("rel_busy", busy, 1'b0);

        // Frame 1: plain transfer, latency measurement
        set_core(40'hEEDDCCBBAA);
        send_byte(8'h01, 0);
        check("f1_inst_busy", {inst, busy}, {3'd1, 1'b1});
        send_ops(40'h0504030201, 40'h5040302010, 0);
        check_ops(40'h0504030201, 40'h5040302010, 3'd1);
        wait_valid(cyc);
        check("f1_latency", 64'(cyc), 64'(LATENCY + 1));
        recv(40'hEEDDCCBBAA, -1, 0, 1'b0, 8'h00);
        @(negedge clk);
        check("f1_done_once", {done, 32'(done_cnt)}, {1'b0, 32'd1});

        // Frame 2: in_valid toggling, 7-cycle stall on byte 2
        set_core(40'hEEDDCCBBAA);
        send_byte(8'h01, 1);
        send_ops(40'h0504030201, 40'h5040302010, 1);
        check_ops(40'h0504030201, 40'h5040302010, 3'd1);
        wait_valid(cyc);
        check("f2_latency", 64'(cyc), 64'(LATENCY + 1));
        recv(40'hEEDDCCBBAA, 2, 7, 1'b0, 8'h00);

        // Frame 3: upper cmd bits ignored
        set_core(40'h0102030405);
        send_byte(8'hFA, 0);
        check("f3_inst", inst, 3'b010);
        send_ops(40'hC1C2C3C4C5, 40'hD1D2D3D4D5, 0);
        check_ops(40'hC1C2C3C4C5, 40'hD1D2D3D4D5, 3'b010);
        recv(40'h0102030405, -1, 0, 1'b0, 8'h00);

        // Frame 4: reset in WAIT aborts
        set_core(40'h7777777777);
        send_byte(8'h03, 0);
        send_ops(40'h0A0B0C0D0E, 40'h1A1B1C1D1E, 0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_flags", {in_ready, out_valid, busy, done}, 4'b0000);
        check("abort_regs", {inst, a4, a3, a2, a1, a0, b4, b3, b2, b1, b0}, 83'h0);
        ov_seen = 1'b0;
        repeat (LATENCY + 4) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || done !== 1'b0) ov_seen = 1'b1;
        end
        check("abort_no_output", ov_seen, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_done_cnt", 64'(done_cnt), 64'd3);

        // Frame 5: full frame after abort
        set_core(40'h1234567890);
        send_byte(8'h04, 0);
        send_ops(40'h0102030405, 40'hA0B0C0D0E0, 0);
        check_ops(40'h0102030405, 40'hA0B0C0D0E0, 3'd4);
        wait_valid(cyc);
        check("f5_latency", 64'(cyc), 64'(LATENCY + 1));
        recv(40'h1234567890, -1, 0, 1'b0, 8'h00);

        // Frames 6/7: next cmd offered during the last result accept
        set_core(40'h5544332211);
        send_byte(8'h02, 0);
        send_ops(40'h0F0E0D0C0B, 40'h1F1E1D1C1B, 0);
        check_ops(40'h0F0E0D0C0B, 40'h1F1E1D1C1B, 3'd2);
        recv(40'h5544332211, -1, 0, 1'b1, 8'h06);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_cmd_taken", {busy, inst, in_ready, done}, {1'b1, 3'd6, 1'b1, 1'b0});
        set_core(40'h9988776655);
        send_ops(40'h2A2B2C2D2E, 40'h3A3B3C3D3E, 0);
        check_ops(40'h2A2B2C2D2E, 40'h3A3B3C3D3E, 3'd6);
        wait_valid(cyc);
        check("f7_latency", 64'(cyc), 64'(LATENCY + 1));
        recv(40'h9988776655, -1, 0, 1'b0, 8'h00);
        @(negedge clk);
        check("total_done_cnt", 64'(done_cnt), 64'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
